conv_result_collector: RTL

CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

---
 rtl/conv_result_collector.sv | 120 ++++++++++++
 1 files changed

// File: rtl/conv_result_collector.sv
// Collects float16 convolution results, one per in_valid rising edge, into a
// result_width x result_length map and hands it downstream with a valid/ready hold.
module conv_result_collector #(
    parameter int data_width    = 16,
    parameter int result_length = 2,
    parameter int result_width  = 2,
    parameter int relu_en       = 0
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            conv_en,
    input  logic [data_width-1:0]                           in_result,
    input  logic                                            in_valid,
    output logic [data_width-1:0]                           anchor_2D,
    output logic [data_width-1:0]                           anchor_1D,
    output logic [0:result_length*result_width*data_width-1] fmap,
    output logic                                            fmap_valid,
    input  logic                                            fmap_ready,
    output logic                                            busy
);

    localparam int map_bits = result_length * result_width * data_width;
    localparam logic [data_width-1:0] last_col = data_width'(result_length - 1);
    localparam logic [data_width-1:0] last_row = data_width'(result_width - 1);
    localparam logic [data_width-1:0] one      = data_width'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [data_width-1:0]   anchor_2d_q, anchor_2d_d;
    logic [data_width-1:0]   anchor_1d_q, anchor_1d_d;
    logic [0:map_bits-1]     fmap_q, fmap_d;
    logic                    fmap_valid_q, fmap_valid_d;
    logic                    in_valid_prev_q, in_valid_prev_d;
    logic [data_width-1:0]   store_val;

    // Sign bit set means negative, including -0, so it clamps to +0 under ReLU.
    assign store_val = (relu_en != 0 && in_result[data_width-1]) ? '0 : in_result;

    always_comb begin
        state_d         = state_q;
        anchor_2d_d     = anchor_2d_q;
        anchor_1d_d     = anchor_1d_q;
        fmap_d          = fmap_q;
        fmap_valid_d    = fmap_valid_q;
        in_valid_prev_d = in_valid;
        case (state_q)
            IDLE: begin
                if (conv_en) begin
                    state_d         = COLLECT;
                    anchor_2d_d     = '0;
                    anchor_1d_d     = '0;
                    in_valid_prev_d = 1'b0;
                end
            end
            COLLECT: begin
                // Abort takes priority over a coincident accept.
                if (!conv_en) begin
                    state_d     = IDLE;
                    anchor_2d_d = '0;
                    anchor_1d_d = '0;
                end else if (in_valid && !in_valid_prev_q) begin
                    for (int r = 0; r < result_width; r++) begin
                        for (int c = 0; c < result_length; c++) begin
                            if (anchor_2d_q == data_width'(r) && anchor_1d_q == data_width'(c)) begin
                                fmap_d[(r*result_length+c)*data_width +: data_width] = store_val;
                            end
                        end
                    end
                    if (anchor_1d_q == last_col) begin
                        anchor_1d_d = '0;
                        if (anchor_2d_q == last_row) begin
                            anchor_2d_d  = '0;
                            state_d      = HOLD;
                            fmap_valid_d = 1'b1;
                        end else begin
                            anchor_2d_d = anchor_2d_q + one;
                        end
                    end else begin
                        anchor_1d_d = anchor_1d_q + one;
                    end
                end
            end
            HOLD: begin
                if (fmap_ready) begin
                    fmap_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            anchor_2d_q     <= '0;
            anchor_1d_q     <= '0;
            fmap_q          <= '0;
            fmap_valid_q    <= 1'b0;
            in_valid_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            anchor_2d_q     <= anchor_2d_d;
            anchor_1d_q     <= anchor_1d_d;
            fmap_q          <= fmap_d;
            fmap_valid_q    <= fmap_valid_d;
            in_valid_prev_q <= in_valid_prev_d;
        end
    end

    assign anchor_2D  = anchor_2d_q;
    assign anchor_1D  = anchor_1d_q;
    assign fmap       = fmap_q;
    assign fmap_valid = fmap_valid_q;
    assign busy       = (state_q == COLLECT);

endmodule
